// File: rtl/run_ctrl.sv
// run_ctrl: sequences CPU reset, counts run/retired cycles, stops on halt PC, self-loop or timeout
// Ports: clk, rst (sync, active-high); start pulse begins a run from IDLE or DONE;
//   halt_pc/halt_pc_en arm the PC-match stop; pc_w/pc_w_valid observe writeback retirements;
//   cpu_rst/cpu_en drive the core; running/done/done_cause report state (cause 1 timeout,
//   2 pc match, 3 self-loop); cycle_count/retired_count are saturating RUN statistics.
module run_ctrl #(
   parameter int XLEN        = 32,
   parameter int CNT_W       = 32,
   parameter int RST_CYCLES  = 2,
   parameter int MAX_CYCLES  = 40,
   parameter int LOOP_REPEAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [XLEN-1:0]  halt_pc,
   input  logic             halt_pc_en,
   input  logic [XLEN-1:0]  pc_w,
   input  logic             pc_w_valid,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             running,
   output logic             done,
   output logic [1:0]       done_cause,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count
);
   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
   localparam int RC = RST_CYCLES < 1 ? 1 : RST_CYCLES;
   localparam int RW = $clog2(RC + 1);
   localparam logic [CNT_W-1:0] ONES = '1;
   state_t state;
   logic [RW-1:0] rst_cnt;
   logic [XLEN-1:0] last_pc;
   logic [31:0] loop_cnt, loop_nxt;
   logic [CNT_W-1:0] cyc_nxt, ret_nxt;
   logic pc_hit, loop_hit, to_hit;
   // loop_cnt==0 means no retirement yet this run, so the first one never matches last_pc
   always_comb begin
      loop_nxt = (loop_cnt != 32'd0 && pc_w == last_pc) ? loop_cnt + 32'd1 : 32'd1;
      pc_hit   = pc_w_valid & halt_pc_en & (pc_w == halt_pc);
      loop_hit = pc_w_valid & (LOOP_REPEAT != 0) & (loop_nxt == 32'(LOOP_REPEAT));
      to_hit   = (MAX_CYCLES != 0) && (64'(cycle_count) == 64'(MAX_CYCLES) - 64'd1);
      cyc_nxt  = cycle_count == ONES ? cycle_count : cycle_count + CNT_W'(1);
      ret_nxt  = (pc_w_valid && retired_count != ONES) ? retired_count + CNT_W'(1) : retired_count;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cpu_rst       <= 1'b1;
         cpu_en        <= 1'b0;
         running       <= 1'b0;
         done          <= 1'b0;
         done_cause    <= 2'd0;
         cycle_count   <= '0;
         retired_count <= '0;
         loop_cnt      <= '0;
         last_pc       <= '0;
         rst_cnt       <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state         <= RESET;
               cpu_rst       <= 1'b1;
               cpu_en        <= 1'b0;
               running       <= 1'b0;
               done          <= 1'b0;
               done_cause    <= 2'd0;
               cycle_count   <= '0;
               retired_count <= '0;
               loop_cnt      <= '0;
               rst_cnt       <= RW'(RC);
            end
            RESET: if (rst_cnt <= RW'(1)) begin
               state   <= RUN;
               cpu_rst <= 1'b0;
               cpu_en  <= 1'b1;
               running <= 1'b1;
            end else rst_cnt <= rst_cnt - RW'(1);
            default: begin
               cycle_count   <= cyc_nxt;
               retired_count <= ret_nxt;
               if (pc_w_valid) begin
                  last_pc  <= pc_w;
                  loop_cnt <= loop_nxt;
               end
               if (pc_hit | loop_hit | to_hit) begin
                  state      <= DONE;
                  cpu_en     <= 1'b0;
                  running    <= 1'b0;
                  done       <= 1'b1;
                  done_cause <= pc_hit ? 2'd2 : loop_hit ? 2'd3 : 2'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scoreboard bench for run_ctrl
module tb_run_ctrl;
   logic clk = 0, rst = 1, st0 = 0, st1 = 0, st2 = 0, halt_en = 0, valid = 0;
   logic [31:0] halt_pc = 0, pc = 0;
   logic cr[4], ce[4], ru[4], dn[4];
   logic [1:0] dc[4];
   logic [31:0] cc[3], rc[3];
   logic [3:0] cc3, rc3;
   int tests = 0, fails = 0, n, bad;
   typedef struct {logic [1:0] cause; logic [31:0] cyc; logic [31:0] ret;} exp_t;
   exp_t sb[$];
   logic [31:0] seq_loop[5] = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h18};
   logic [31:0] seq_nof[4]  = '{32'h18, 32'h18, 32'h1C, 32'h18};

   always #5 clk = ~clk;

   run_ctrl u0 (.clk(clk), .rst(rst), .start(st0), .halt_pc(halt_pc), .halt_pc_en(halt_en),
      .pc_w(pc), .pc_w_valid(valid), .cpu_rst(cr[0]), .cpu_en(ce[0]), .running(ru[0]),
      .done(dn[0]), .done_cause(dc[0]), .cycle_count(cc[0]), .retired_count(rc[0]));
   run_ctrl #(.MAX_CYCLES(5)) u1 (.clk(clk), .rst(rst), .start(st1), .halt_pc(halt_pc),
      .halt_pc_en(halt_en), .pc_w(pc), .pc_w_valid(valid), .cpu_rst(cr[1]), .cpu_en(ce[1]),
      .running(ru[1]), .done(dn[1]), .done_cause(dc[1]), .cycle_count(cc[1]), .retired_count(rc[1]));
   run_ctrl #(.MAX_CYCLES(0), .LOOP_REPEAT(0)) u2 (.clk(clk), .rst(rst), .start(st2),
      .halt_pc(halt_pc), .halt_pc_en(1'b0), .pc_w(pc), .pc_w_valid(valid), .cpu_rst(cr[2]),
      .cpu_en(ce[2]), .running(ru[2]), .done(dn[2]), .done_cause(dc[2]), .cycle_count(cc[2]),
      .retired_count(rc[2]));
   run_ctrl #(.CNT_W(4), .MAX_CYCLES(0), .LOOP_REPEAT(0)) u3 (.clk(clk), .rst(rst), .start(st2),
      .halt_pc(halt_pc), .halt_pc_en(1'b0), .pc_w(pc), .pc_w_valid(valid), .cpu_rst(cr[3]),
      .cpu_en(ce[3]), .running(ru[3]), .done(dn[3]), .done_cause(dc[3]), .cycle_count(cc3),
      .retired_count(rc3));

   task tick();
      @(negedge clk);
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_run(logic [1:0] c, int cy, int r);
      exp_t e;
      e.cause = c;
      e.cyc = 32'(cy);
      e.ret = 32'(r);
      sb.push_back(e);
   endtask

   task automatic score(string tag, logic [1:0] c, logic [31:0] cy, logic [31:0] r);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_cause"}, 64'(c), 64'(e.cause));
      chk({tag, "_cycles"}, 64'(cy), 64'(e.cyc));
      chk({tag, "_retired"}, 64'(r), 64'(e.ret));
   endtask

   task automatic start0_run();
      int k;
      st0 = 1;
      tick();
      st0 = 0;
      chk("clr_cycles", 64'(cc[0]), 64'd0);
      chk("clr_retired", 64'(rc[0]), 64'd0);
      chk("clr_done", 64'(dn[0]), 64'd0);
      k = 0;
      while (cr[0] && k < 10) begin
         k++;
         tick();
      end
      chk("rst_cycles", 64'(k), 64'd2);
      chk("run_entry", 64'(ru[0]), 64'd1);
   endtask

   task automatic wait_done0(int budget);
      int k = 0;
      while (!dn[0] && k < budget) begin
         k++;
         tick();
      end
      chk("done_seen", 64'(dn[0]), 64'd1);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_cpu_rst", 64'(cr[0]), 64'd1);
      chk("rst_cpu_en", 64'(ce[0]), 64'd0);
      chk("rst_running", 64'(ru[0]), 64'd0);
      chk("rst_done", 64'(dn[0]), 64'd0);
      chk("rst_cause", 64'(dc[0]), 64'd0);
      chk("rst_cycles", 64'(cc[0]), 64'd0);
      rst = 0;
      tick();
      // timeout with no retirements
      expect_run(2'd1, 40, 0);
      start0_run();
      n = 0;
      bad = 0;
      while (ru[0] && n < 100) begin
         if (!ce[0] || cr[0]) bad++;
         n++;
         tick();
      end
      chk("run_len", 64'(n), 64'd40);
      chk("run_en", 64'(bad), 64'd0);
      chk("to_done", 64'(dn[0]), 64'd1);
      chk("to_cpu_rst", 64'(cr[0]), 64'd0);
      score("timeout", dc[0], cc[0], rc[0]);
      // halt PC match
      halt_pc = 32'h24;
      halt_en = 1;
      expect_run(2'd2, 10, 10);
      start0_run();
      for (int i = 0; i < 10; i++) begin
         pc = 32'(i * 4);
         valid = 1;
         tick();
      end
      valid = 0;
      chk("pc_done", 64'(dn[0]), 64'd1);
      chk("pc_cpu_en", 64'(ce[0]), 64'd0);
      score("pcmatch", dc[0], cc[0], rc[0]);
      // self-loop
      halt_en = 0;
      expect_run(2'd3, 5, 5);
      start0_run();
      for (int i = 0; i < 5; i++) begin
         pc = seq_loop[i];
         valid = 1;
         tick();
      end
      valid = 0;
      chk("loop_done", 64'(dn[0]), 64'd1);
      score("selfloop", dc[0], cc[0], rc[0]);
      // near-loop sequence must not fire; run ends by timeout
      expect_run(2'd1, 40, 4);
      start0_run();
      for (int i = 0; i < 4; i++) begin
         pc = seq_nof[i];
         valid = 1;
         tick();
      end
      valid = 0;
      chk("noloop_running", 64'(ru[0]), 64'd1);
      wait_done0(100);
      score("noloop", dc[0], cc[0], rc[0]);
      // pc match and timeout on the same cycle
      halt_pc = 32'h110;
      halt_en = 1;
      expect_run(2'd2, 5, 5);
      st1 = 1;
      tick();
      st1 = 0;
      n = 0;
      while (cr[1] && n < 10) begin
         n++;
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         pc = 32'h100 + 32'(i * 4);
         valid = 1;
         tick();
      end
      valid = 0;
      chk("simul_done", 64'(dn[1]), 64'd1);
      score("simul", dc[1], cc[1], rc[1]);
      // reset mid-run
      halt_en = 0;
      start0_run();
      repeat (7) tick();
      chk("mid_cycles", 64'(cc[0]), 64'd7);
      rst = 1;
      tick();
      rst = 0;
      chk("mid_cpu_rst", 64'(cr[0]), 64'd1);
      chk("mid_running", 64'(ru[0]), 64'd0);
      chk("mid_cpu_en", 64'(ce[0]), 64'd0);
      chk("mid_cycles0", 64'(cc[0]), 64'd0);
      chk("mid_done", 64'(dn[1]), 64'd0);
      // all stops disabled, plus 4-bit saturation
      halt_pc = 32'h40;
      halt_en = 1;
      pc = 32'h40;
      valid = 1;
      st2 = 1;
      tick();
      st2 = 0;
      n = 0;
      while (cr[2] && n < 10) begin
         n++;
         tick();
      end
      bad = 0;
      repeat (1000) begin
         if (!ru[2]) bad++;
         tick();
      end
      valid = 0;
      chk("dis_drop", 64'(bad), 64'd0);
      chk("dis_running", 64'(ru[2]), 64'd1);
      chk("dis_cycles", 64'(cc[2]), 64'd1000);
      chk("dis_retired", 64'(rc[2]), 64'd1000);
      chk("sat_cycles", 64'(cc3), 64'd15);
      chk("sat_retired", 64'(rc3), 64'd15);
      chk("sat_running", 64'(ru[3]), 64'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Synthesizable run controller for the pipelined CPU bench and FPGA harness. It sequences CPU reset, counts run and retired-instruction cycles, and stops the core on one of three events: a programmable halt PC, a self-loop ("j .") on the writeback PC, or a cycle timeout. It replaces the fixed 40-cycle stop in the simulation bench with a parametrised, reusable block that sits between the harness and Top.

Parameters:
XLEN, 32, PC width
CNT_W, 32, width of cycle_count and retired_count
RST_CYCLES, 2, cycles cpu_rst is held after start (min 1; a value of 0 behaves as 1)
MAX_CYCLES, 40, run-cycle timeout; 0 disables timeout
LOOP_REPEAT, 3, consecutive retirements of the same PC that mean self-loop; 0 disables

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
start  in  1  single-cycle pulse; begins a run from IDLE or DONE
halt_pc  in  XLEN  halt address
halt_pc_en  in  1  enables halt_pc match
pc_w  in  XLEN  writeback-stage PC
pc_w_valid  in  1  a valid instruction retires this cycle
cpu_rst  out  1  active-high reset to the CPU core
cpu_en  out  1  CPU clock enable; 0 freezes the core
running  out  1  high in RUN
done  out  1  sticky; high in DONE
done_cause  out  2  0 none, 1 timeout, 2 pc match, 3 self-loop
cycle_count  out  CNT_W  RUN cycles elapsed
retired_count  out  CNT_W  valid retirements in RUN

Behaviour:
- The state machine has four states: IDLE, RESET, RUN, DONE. All outputs are registered.
- Reset (rst=1 at an edge, in any state, including mid-run):
  - state goes to IDLE.
  - cpu_rst=1, cpu_en=0, running=0, done=0, done_cause=0.
  - both counters clear, the loop counter clears, and the last-PC register clears.
- IDLE:
  - cpu_rst=1, cpu_en=0.
  - start moves to RESET. On that edge, both counters and done_cause clear and the reset counter loads.
- RESET:
  - cpu_rst=1, cpu_en=0 for exactly RST_CYCLES cycles, then RUN.
  - start is ignored.
- RUN:
  - cpu_rst=0, cpu_en=1, running=1.
  - cycle_count increments every cycle. retired_count increments on pc_w_valid.
  - Both counters saturate at all-ones and do not wrap.
- Stop conditions, evaluated on the same cycle's inputs:
  - pc match: pc_w_valid & halt_pc_en & pc_w==halt_pc.
  - self-loop: pc_w_valid & pc_w==last_pc makes the loop counter increment; a valid retirement with a different PC resets it to 1. The condition fires when the count reaches LOOP_REPEAT. last_pc updates on every valid retirement. The first retirement in a run never matches.
  - timeout: cycle_count==MAX_CYCLES-1 in this cycle, meaning exactly MAX_CYCLES RUN cycles have elapsed.
  - Priority when several fire in one cycle: pc match > self-loop > timeout.
- Latency: a condition sampled at edge t gives done=1, running=0, cpu_en=0 and a valid done_cause after edge t.
  - The retirement that triggered the stop is counted.
  - The cycle is counted, so cycle_count equals the number of RUN cycles.
- DONE:
  - cpu_en=0, cpu_rst=0, so the core is frozen for inspection.
  - done and done_cause hold, and counters freeze.
  - start moves to RESET, clears done, done_cause and counters, and the next run begins.
- start during RUN is ignored. rst takes priority over start on the same edge.
- pc_w_valid outside RUN is ignored.

Test Plan:
- Timeout: defaults, no retirements, pulse start at cycle 0.
  - cpu_rst is high for 2 cycles.
  - running is high for exactly 40 cycles.
  - Then done=1, done_cause=1, cycle_count=40, retired_count=0.
- PC match: halt_pc=0x0000_0024, halt_pc_en=1; retire PCs 0x00,0x04,…,0x24, one per cycle.
  - done_cause=2 one cycle after 0x24 retires.
  - retired_count=10, cpu_en=0.
- Self-loop: retire 0x10, 0x14, then 0x18 three times in a row.
  - done_cause=3, retired_count=5.
  - A 0x18,0x18,0x1C,0x18 sequence must not fire.
- Simultaneous: MAX_CYCLES=5; halt_pc equals the PC retired in the 5th RUN cycle.
  - Requires done_cause=2, not 1.
- Restart and reset:
  - After DONE, start again: counters return to 0, cpu_rst is high for 2 cycles, and the second run matches the first.
  - Asserting rst mid-RUN at cycle 7 gives IDLE, cpu_rst=1, counters=0 the next cycle.
- Disables and saturation:
  - MAX_CYCLES=0, LOOP_REPEAT=0, halt_pc_en=0: run 1000 cycles and running stays 1.
  - With CNT_W=4, cycle_count saturates at 15.
